// File: rtl/div_rem_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock; special cases resolve in IDLE.
module div_rem_unit #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [1:0]       i_div_op,
   input  logic [WIDTH-1:0] i_op_a,
   input  logic [WIDTH-1:0] i_op_b,
   output logic             o_busy,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_div_data
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [1:0]       op;
   logic             neg_q;
   logic             neg_r;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvsr;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] data;
   logic             valid;

   logic             is_signed;
   logic             is_rem;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic             div_zero;
   logic             ovf;
   logic             special;
   logic [WIDTH-1:0] special_res;

   logic [WIDTH:0]   shift;
   logic [WIDTH:0]   diff;
   logic             q_bit;
   logic             last;
   logic [WIDTH-1:0] result;

   // Operand conditioning and special-case detection at issue.
   always_comb begin
      is_signed   = ~i_div_op[0];
      is_rem      = i_div_op[1];
      abs_a       = i_op_a[WIDTH-1] ? -i_op_a : i_op_a;
      abs_b       = i_op_b[WIDTH-1] ? -i_op_b : i_op_b;
      div_zero    = (i_op_b == '0);
      ovf         = is_signed
                  && (i_op_a == {1'b1, {(WIDTH-1){1'b0}}})
                  && (i_op_b == '1);
      special     = div_zero | ovf;
      special_res = '0;
      if (div_zero) begin
         special_res = is_rem ? i_op_a : '1;
      end else if (ovf) begin
         special_res = is_rem ? '0 : i_op_a;
      end
   end

   // One restoring step: shift in dividend MSB, trial subtract.
   always_comb begin
      shift = {rem, quo[WIDTH-1]};
      diff  = shift - {1'b0, dvsr};
      q_bit = ~diff[WIDTH];
      last  = (cnt == CW'(WIDTH - 1));
   end

   // Sign fix-up of the selected quotient or remainder.
   always_comb begin
      result = '0;
      if (op[1]) begin
         result = neg_r ? -rem : rem;
      end else begin
         result = neg_q ? -quo : quo;
      end
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; unreachable encodings fall back to IDLE.
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE: state_nxt = (i_start && !special) ? CALC : IDLE;
         CALC: state_nxt = last ? FIX : CALC;
         FIX:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode from state.
   always_comb begin
      o_busy = (state != IDLE);
   end

   // Datapath: operand capture, iteration and result register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op    <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         quo   <= '0;
         rem   <= '0;
         dvsr  <= '0;
         cnt   <= '0;
         data  <= '0;
         valid <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  op  <= i_div_op;
                  rem <= '0;
                  cnt <= '0;
                  if (is_signed) begin
                     quo   <= abs_a;
                     dvsr  <= abs_b;
                     neg_q <= i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1];
                     neg_r <= i_op_a[WIDTH-1];
                  end else begin
                     quo   <= i_op_a;
                     dvsr  <= i_op_b;
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                  end
                  if (special) begin
                     data  <= special_res;
                     valid <= 1'b1;
                  end
               end
            end
            CALC: begin
               rem <= q_bit ? diff[WIDTH-1:0] : shift[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], q_bit};
               if (!last) begin
                  cnt <= cnt + 1'b1;
               end
            end
            FIX: begin
               data  <= result;
               valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_valid    = valid;
   assign o_div_data = data;

endmodule
